crc16_frame_tx: RTL and testbench
=================================

// Module: crc16_frame_tx
// PURPOSE
//  Byte-stream framer that sits directly upstream of the crc16 core.
//  - Passes payload bytes from an upstream source to a downstream byte sink.
//  - Drives the crc16 core's clr/clk_en/d inputs as each byte is transferred.
//  - After the last payload byte, appends the 16-bit CRC-CCITT (init 0xFFFF), MSB first.
// PARAMETERS
//  MAX_LEN  4095  max payload bytes per frame (crc16 guaranteed-detection limit)
//  CNT_W    12    byte-counter width; must satisfy 2**CNT_W > MAX_LEN
// PORTS
//  clk        in   1   system clock, all logic on posedge
//  reset      in   1   synchronous, active-low reset
//  in_data    in   8   payload byte
//  in_valid   in   1   in_data valid
//  in_last    in   1   qualifies in_data as final payload byte of frame
//  in_ready   out  1   framer accepts in_data this cycle
//  out_data   out  8   byte to sink (payload or CRC byte)
//  out_valid  out  1   out_data valid
//  out_last   out  1   high with CRC low byte (final byte of frame)
//  out_ready  in   1   sink accepts out_data this cycle
//  crc_clr    out  1   to crc16 clr (active-low clear to 0xFFFF)
//  crc_en     out  1   to crc16 clk_en
//  crc_d      out  8   to crc16 d
//  crc_in     in   16  from crc16 data_out
//  len_err    out  1   1-cycle pulse: frame truncated at MAX_LEN
// BEHAVIOUR
//  Timing and reset
//  - Transfer = valid & ready on the same posedge.
//  - reset=0 at a posedge: state<=CLEAR, cnt<=0, len_err<=0.
//  - Applies mid-frame too: partial frame is dropped, no CRC bytes emitted.
//  - Registered outputs are 0 out of reset.
//  FSM states: CLEAR, DATA, CRC_HI, CRC_LO
//  - CLEAR: crc_clr=0, in_ready=0, out_valid=0. Next cycle always goes to DATA.
//  - DATA (combinational pass-through):
//    - out_data=in_data, out_valid=in_valid, in_ready=out_ready, out_last=0.
//    - crc_d=in_data, crc_en=in_valid&out_ready, crc_clr=1.
//    - On each transfer, cnt<=cnt+1.
//    - Transfer with in_last=1, or with cnt==MAX_LEN-1: go to CRC_HI, cnt<=0.
//    - MAX_LEN case with in_last=0: len_err=1 for one cycle. Following input bytes start a new frame.
//  - CRC_HI: out_data=crc_in[15:8], out_valid=1, in_ready=0, crc_en=0.
//    - On out_ready: go to CRC_LO.
//  - CRC_LO: out_data=crc_in[7:0], out_valid=1, out_last=1, in_ready=0, crc_en=0.
//    - On out_ready: go to CLEAR.
//  CRC sourcing and latency
//  - crc16 updates r on the edge that transfers the last byte, so crc_in is final in CRC_HI.
//  - crc_in is stable through CRC_LO because crc_en=0.
//  Per-frame overhead and stalls
//  - Overhead: 2 CRC cycles + 1 CLEAR cycle. Throughput 1 byte/clk inside DATA.
//  - out_ready=0 in CRC_HI/CRC_LO: hold state and out_data stable (no skipped or repeated byte).
//  - in_valid while in_ready=0 is ignored; the source must hold the byte.
//  Frame length and sink rules
//  - A 1-byte frame (in_last on first byte) is legal. Zero-length frames do not exist.
//  - out_valid never drops without a transfer once asserted (AXI-style). Payload bytes are exempt: they follow in_valid.
// TESTING
//  1) Payload "123456789" (0x31..0x39, last on 0x39), out_ready=1
//     -> out = 31..39, 29, B1 (out_last on B1); crc_en high exactly 9 cycles.
//  2) Single byte 0x00 with in_last -> out 00, E1, F0.
//     Back-to-back second frame 0x00 -> same E1, F0 (proves CLEAR reinit).
//  3) Random out_ready stalls during payload and CRC bytes
//     -> byte sequence and CRC of test 1 unchanged; no duplicates or drops.
//  4) MAX_LEN=4 override, 6 bytes without last
//     -> CRC after byte 4, len_err pulse once, bytes 5-6 start a new frame.
//  5) reset=0 for one cycle in DATA after 3 bytes, then "123456789"
//     -> no CRC for partial frame; new frame gives 29, B1.
//  6) reset=0 during CRC_HI stall
//     -> out_valid=0 next cycle, state CLEAR, len_err=0.

Source files
------------

// File: rtl/crc16_frame_tx.sv
// Byte-stream framer feeding an external crc16 core: passes payload bytes through,
// then appends the core's CRC-CCITT result MSB first, truncating frames at MAX_LEN bytes.
module crc16_frame_tx #(
  parameter int unsigned MAX_LEN = 4095,
  parameter int unsigned CNT_W   = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
  output logic        crc_clr,
  output logic        crc_en,
  output logic [7:0]  crc_d,
  input  logic [15:0] crc_in,
  output logic        len_err
);

  typedef enum logic [1:0] {CLEAR, DATA, CRC_HI, CRC_LO} state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_LEN - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             len_err_q, len_err_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= CLEAR;
      cnt_q     <= '0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_err_q <= len_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_err_d = 1'b0;
    in_ready  = 1'b0;
    out_data  = '0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    crc_clr   = 1'b1;
    crc_en    = 1'b0;
    crc_d     = in_data;

    unique case (state_q)
      CLEAR: begin
        crc_clr = 1'b0;
        state_d = DATA;
      end
      DATA: begin
        out_data  = in_data;
        out_valid = in_valid;
        in_ready  = out_ready;
        crc_en    = in_valid & out_ready;
        if (in_valid && out_ready) begin
          cnt_d = cnt_q + 1'b1;
          // Hitting MAX_LEN closes the frame; later bytes open a fresh one.
          if (in_last || cnt_q == CNT_LAST) begin
            state_d   = CRC_HI;
            cnt_d     = '0;
            len_err_d = ~in_last;
          end
        end
      end
      CRC_HI: begin
        out_data  = crc_in[15:8];
        out_valid = 1'b1;
        if (out_ready) state_d = CRC_LO;
      end
      CRC_LO: begin
        out_data  = crc_in[7:0];
        out_valid = 1'b1;
        out_last  = 1'b1;
        if (out_ready) state_d = CLEAR;
      end
      default: state_d = CLEAR;
    endcase
  end

  assign len_err = len_err_q;

endmodule

// File: tb/tb_crc16_frame_tx.sv
// Randomized bench for crc16_frame_tx: a default instance and a MAX_LEN=4 instance,
// each backed by a crc16 core model, checked against a frame-level reference model.
module tb_crc16_frame_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, sel, stall_on;
  logic [7:0] in_data;
  logic       in_valid, in_last, out_ready;

  logic        in_valid0, in_ready0, out_valid0, out_last0, out_ready0, crc_clr0, crc_en0, len_err0;
  logic [7:0]  out_data0, crc_d0;
  logic [15:0] crc_r0 = 16'hFFFF;
  logic        in_valid1, in_ready1, out_valid1, out_last1, out_ready1, crc_clr1, crc_en1, len_err1;
  logic [7:0]  out_data1, crc_d1;
  logic [15:0] crc_r1 = 16'hFFFF;

  logic       in_ready_m, out_valid_m, out_last_m, crc_clr_m, crc_en_m, len_err_m;
  logic [7:0] out_data_m;

  assign in_valid0   = in_valid & ~sel;
  assign in_valid1   = in_valid & sel;
  assign out_ready0  = sel ? 1'b1 : out_ready;
  assign out_ready1  = sel ? out_ready : 1'b1;
  assign in_ready_m  = sel ? in_ready1  : in_ready0;
  assign out_valid_m = sel ? out_valid1 : out_valid0;
  assign out_last_m  = sel ? out_last1  : out_last0;
  assign out_data_m  = sel ? out_data1  : out_data0;
  assign crc_clr_m   = sel ? crc_clr1   : crc_clr0;
  assign crc_en_m    = sel ? crc_en1    : crc_en0;
  assign len_err_m   = sel ? len_err1   : len_err0;

  crc16_frame_tx dut0 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid0), .in_last(in_last),
    .in_ready(in_ready0), .out_data(out_data0), .out_valid(out_valid0), .out_last(out_last0),
    .out_ready(out_ready0), .crc_clr(crc_clr0), .crc_en(crc_en0), .crc_d(crc_d0),
    .crc_in(crc_r0), .len_err(len_err0)
  );

  crc16_frame_tx #(.MAX_LEN(4), .CNT_W(3)) dut4 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid1), .in_last(in_last),
    .in_ready(in_ready1), .out_data(out_data1), .out_valid(out_valid1), .out_last(out_last1),
    .out_ready(out_ready1), .crc_clr(crc_clr1), .crc_en(crc_en1), .crc_d(crc_d1),
    .crc_in(crc_r1), .len_err(len_err1)
  );

  function automatic logic [15:0] crc_step(input logic [15:0] c_in, input logic [7:0] d);
    logic [15:0] c;
    c = c_in ^ {d, 8'h00};
    for (int b = 0; b < 8; b++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    return c;
  endfunction

  function automatic logic [15:0] crc_of(input logic [7:0] q[$]);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (q[i]) c = crc_step(c, q[i]);
    return c;
  endfunction

  // Stand-ins for the crc16 cores the framer drives.
  always @(posedge clk) begin
    if (!crc_clr0) crc_r0 <= 16'hFFFF;
    else if (crc_en0) crc_r0 <= crc_step(crc_r0, crc_d0);
  end
  always @(posedge clk) begin
    if (!crc_clr1) crc_r1 <= 16'hFFFF;
    else if (crc_en1) crc_r1 <= crc_step(crc_r1, crc_d1);
  end

  int unsigned n_checks = 0, n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  logic [7:0]  outq[$], seen[$], pay[$];
  logic        lastq[$], lst[$];
  int unsigned frames_done = 0, en_cnt = 0, lerr_cnt = 0, stab_err = 0;
  logic        have_stall = 1'b0;
  logic [7:0]  stall_data = '0;

  // Sink-side monitor: records transfers and checks that stalled non-payload bytes hold.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      have_stall = 1'b0;
    end else begin
      if (crc_en_m) en_cnt++;
      if (len_err_m) lerr_cnt++;
      if (have_stall && (!out_valid_m || out_data_m != stall_data)) stab_err++;
      have_stall = out_valid_m && !out_ready && !in_valid;
      stall_data = out_data_m;
      if (out_valid_m && out_ready) begin
        outq.push_back(out_data_m);
        lastq.push_back(out_last_m);
        if (out_last_m) frames_done++;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (stall_on) out_ready = ($urandom_range(0, 99) >= 35);
  end

  task automatic set_stall_off();
    stall_on = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
  endtask

  task automatic drive_byte(input logic [7:0] b, input logic last);
    int unsigned n;
    n = 0;
    in_data  = b;
    in_valid = 1'b1;
    in_last  = last;
    forever begin
      @(negedge clk);
      if (in_ready_m) break;
      n++;
      if (n > 500) begin
        check_eq("in_ready_timeout", n, 0);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    pay.push_back(b);
    lst.push_back(last);
    drive_byte(b, last);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Reference: each frame is its payload, then CRC-CCITT of that payload MSB first.
  // drop_tail removes trailing bytes that a reset prevented from ever being offered.
  task automatic finish_segment(input string tag, input int unsigned maxlen, input int unsigned drop_tail);
    logic [7:0]  cur[$];
    logic [7:0]  eb[$];
    logic        el[$];
    logic [15:0] c;
    int unsigned nfr, nle, n;
    nfr = 0; nle = 0; n = 0;
    foreach (pay[i]) begin
      cur.push_back(pay[i]);
      eb.push_back(pay[i]);
      el.push_back(1'b0);
      if (lst[i] || cur.size() == maxlen) begin
        if (!lst[i]) nle++;
        c = crc_of(cur);
        eb.push_back(c[15:8]); el.push_back(1'b0);
        eb.push_back(c[7:0]);  el.push_back(1'b1);
        cur.delete();
      end
    end
    repeat (drop_tail) begin
      void'(eb.pop_back());
      void'(el.pop_back());
    end
    foreach (el[i]) if (el[i]) nfr++;
    while (frames_done < nfr && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check_eq({tag, "_frames"}, frames_done, nfr);
    check_eq({tag, "_count"}, outq.size(), eb.size());
    for (int i = 0; i < eb.size() && i < outq.size(); i++) begin
      check_eq($sformatf("%s_byte%0d", tag, i), outq[i], eb[i]);
      check_eq($sformatf("%s_last%0d", tag, i), lastq[i], el[i]);
    end
    check_eq({tag, "_crc_en"}, en_cnt, pay.size());
    check_eq({tag, "_len_err"}, lerr_cnt, nle);
    check_eq({tag, "_hold"}, stab_err, 0);
    seen = outq;
    outq.delete(); lastq.delete(); pay.delete(); lst.delete();
    frames_done = 0; en_cnt = 0; lerr_cnt = 0; stab_err = 0;
  endtask

  task automatic send_123456789();
    for (int i = 0; i < 9; i++) send(8'h31 + 8'(i), i == 8);
  endtask

  initial begin
    logic [7:0]  q2[$];
    logic [15:0] c;
    int unsigned len;
    reset = 1'b0; sel = 1'b0; stall_on = 1'b0;
    in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", out_valid_m, 0);
    check_eq("rst_in_ready", in_ready_m, 0);
    check_eq("rst_crc_clr", crc_clr_m, 0);
    check_eq("rst_crc_en", crc_en_m, 0);
    check_eq("rst_len_err", len_err_m, 0);
    check_eq("rst_len_err4", len_err1, 0);
    reset = 1'b1;

    send_123456789();
    finish_segment("t1", 4095, 0);
    check_eq("t1_crc_hi", seen[9], 8'h29);
    check_eq("t1_crc_lo", seen[10], 8'hB1);

    send(8'h00, 1'b1);
    send(8'h00, 1'b1);
    finish_segment("t2", 4095, 0);
    check_eq("t2_crc_hi_a", seen[1], 8'hE1);
    check_eq("t2_crc_lo_a", seen[2], 8'hF0);
    check_eq("t2_crc_hi_b", seen[4], 8'hE1);
    check_eq("t2_crc_lo_b", seen[5], 8'hF0);

    stall_on = 1'b1;
    send_123456789();
    finish_segment("t3", 4095, 0);
    set_stall_off();
    check_eq("t3_crc_hi", seen[9], 8'h29);
    check_eq("t3_crc_lo", seen[10], 8'hB1);

    sel = 1'b1;
    for (int i = 0; i < 6; i++) send(8'($urandom), 1'b0);
    finish_segment("t4", 4, 0);
    pulse_reset();
    for (int i = 0; i < 4; i++) send(8'($urandom), i == 3);
    finish_segment("t4_exact", 4, 0);
    sel = 1'b0;

    for (int i = 0; i < 3; i++) send(8'($urandom), 1'b0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_eq("t5_clear_clr", crc_clr_m, 0);
    check_eq("t5_clear_valid", out_valid_m, 0);
    reset = 1'b1;
    finish_segment("t5_partial", 4095, 0);
    send_123456789();
    finish_segment("t5", 4095, 0);
    check_eq("t5_crc_hi", seen[9], 8'h29);
    check_eq("t5_crc_lo", seen[10], 8'hB1);

    send(8'h41, 1'b0);
    send(8'h42, 1'b1);
    out_ready = 1'b0;
    q2 = '{8'h41, 8'h42};
    c = crc_of(q2);
    @(negedge clk);
    check_eq("t6_hi_valid", out_valid_m, 1);
    check_eq("t6_hi_data", out_data_m, c[15:8]);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_eq("t6_rst_valid", out_valid_m, 0);
    check_eq("t6_rst_len_err", len_err_m, 0);
    check_eq("t6_rst_clr", crc_clr_m, 0);
    check_eq("t6_rst_in_ready", in_ready_m, 0);
    reset = 1'b1;
    out_ready = 1'b1;
    finish_segment("t6_partial", 4095, 2);
    send_123456789();
    finish_segment("t6", 4095, 0);

    stall_on = 1'b1;
    for (int f = 0; f < 8; f++) begin
      sel = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 10);
      for (int j = 0; j < int'(len); j++) begin
        send(8'($urandom), j == int'(len) - 1);
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      finish_segment($sformatf("t7_f%0d", f), sel ? 4 : 4095, 0);
    end
    set_stall_off();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
